// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: owns the PC, reads instruction memory and
// queues {pc, instr} pairs for decode, with redirect flush from EX.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] fetch_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] L_FULL = CW'(DEPTH);

  logic [31:0]   r_pc;
  logic [31:0]   r_fetch_count;
  logic [AW-1:0] r_rptr;
  logic [AW-1:0] r_wptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_mem_pc    [DEPTH];
  logic [31:0]   r_mem_instr [DEPTH];

  logic          w_valid;
  logic          w_pop;
  logic          w_push;
  logic [31:0]   w_redir_pc;
  logic [31:0]   w_head_pc;
  logic [31:0]   w_head_instr;

  assign w_valid    = (r_count != '0);
  assign w_pop      = w_valid & id_ready;
  assign w_push     = ~redirect_valid & ((r_count < L_FULL) | w_pop);
  assign w_redir_pc = redirect_pc & 32'hFFFF_FFFC;

  assign w_head_pc    = r_mem_pc[r_rptr];
  assign w_head_instr = r_mem_instr[r_rptr];

  assign imem_addr      = r_pc;
  assign fetch_count    = r_fetch_count;
  assign if_id_valid    = w_valid;
  assign if_id_pc       = w_valid ? w_head_pc : 32'h0;
  assign if_id_instr    = w_valid ? w_head_instr : 32'h0;
  assign if_id_pc_plus4 = w_valid ? (w_head_pc + 32'd4) : 32'h0;

  // PC and fetch counter: redirect overrides any push
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc          <= RESET_PC;
      r_fetch_count <= 32'h0;
    end else if (redirect_valid) begin
      r_pc <= w_redir_pc;
    end else if (w_push) begin
      r_pc          <= r_pc + 32'd4;
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rptr <= '0;
      r_wptr <= '0;
    end else if (redirect_valid) begin
      r_rptr <= '0;
      r_wptr <= '0;
    end else begin
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
      if (w_push)
        r_wptr <= r_wptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (redirect_valid) begin
      r_count <= '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_pc[i]    <= 32'h0;
        r_mem_instr[i] <= 32'h0;
      end
    end else if (w_push) begin
      r_mem_pc[r_wptr]    <= r_pc;
      r_mem_instr[r_wptr] <= imem_instr;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue against a queue-based fetch model.
// Directed scenarios pin the model with hand-computed values.
module tb_if_fetch_queue;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] fetch_count;

  if_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_instr = memf(imem_addr);

  // model: queued {pc, instr}, next fetch pc, pushes since reset
  logic [63:0] mq[$];
  logic [31:0] mpc;
  logic [31:0] mfc;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  task automatic mreset();
    mq.delete();
    mpc = RESET_PC;
    mfc = 32'h0;
  endtask

  task automatic compare_all();
    logic        v;
    logic [31:0] hp;
    logic [31:0] hi;
    v  = (mq.size() != 0);
    hp = v ? mq[0][63:32] : 32'h0;
    hi = v ? mq[0][31:0]  : 32'h0;
    chk("valid", {31'h0, if_id_valid}, {31'h0, v});
    chk("imem_addr", imem_addr, mpc);
    chk("if_id_pc", if_id_pc, hp);
    chk("if_id_instr", if_id_instr, hi);
    chk("pc_plus4", if_id_pc_plus4, v ? hp + 32'd4 : 32'h0);
    chk("fetch_count", fetch_count, mfc);
  endtask

  // called just after a falling edge; covers one rising edge
  task automatic step(input logic rv, input logic [31:0] rp,
                      input logic rdy, input logic ar);
    logic pop;
    logic push;
    redirect_valid = rv;
    redirect_pc    = rp;
    id_ready       = rdy;
    if (ar) begin
      #1 rst = 1'b0;
      #1;
      mreset();
      chk("arst_valid", {31'h0, if_id_valid}, 32'h0);
      chk("arst_addr", imem_addr, RESET_PC);
      compare_all();
      #1 rst = 1'b1;
    end
    pop  = (mq.size() != 0) && rdy;
    push = !rv && ((mq.size() < DEPTH) || pop);
    if (rv) begin
      mq.delete();
      mpc = rp & 32'hFFFF_FFFC;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back({mpc, memf(mpc)});
        mpc = mpc + 32'd4;
        mfc = mfc + 32'd1;
      end
    end
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  initial begin
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    id_ready       = 1'b0;
    mreset();
    repeat (2) @(negedge clk);
    compare_all();
    chk("rst_addr", imem_addr, RESET_PC);
    rst = 1'b1;

    // streaming after reset release
    id_ready = 1'b1;
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("s1_pc0", if_id_pc, 32'h0);
    chk("s1_valid", {31'h0, if_id_valid}, 32'h1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("s1_pc4", if_id_pc, 32'h4);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("s1_pc8", if_id_pc, 32'h8);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("s1_pc12", if_id_pc, 32'hC);
    chk("s1_fc4", fetch_count, 32'h4);

    // back-pressure saturates the queue
    step(1'b0, 32'h0, 1'b0, 1'b1);
    repeat (4) step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("s2_addr", imem_addr, 32'h8);
    chk("s2_fc", fetch_count, 32'h2);
    chk("s2_head0", if_id_pc, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("s2_head4", if_id_pc, 32'h4);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("s2_head8", if_id_pc, 32'h8);

    // redirect with a full queue and an unaligned target
    step(1'b1, 32'h43, 1'b1, 1'b0);
    chk("s3_valid", {31'h0, if_id_valid}, 32'h0);
    chk("s3_addr", imem_addr, 32'h40);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("s3_pc", if_id_pc, 32'h40);
    chk("s3_plus4", if_id_pc_plus4, 32'h44);

    // pc wrap through 2^32
    step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("s4_addr", imem_addr, 32'hFFFF_FFFC);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("s4_pc", if_id_pc, 32'hFFFF_FFFC);
    chk("s4_plus4", if_id_pc_plus4, 32'h0);
    chk("s4_next", imem_addr, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("s4_wrap", if_id_pc, 32'h0);

    // held redirect keeps the queue empty
    step(1'b1, 32'h100, 1'b1, 1'b0);
    step(1'b1, 32'h200, 1'b1, 1'b0);
    chk("s5_valid", {31'h0, if_id_valid}, 32'h0);
    chk("s5_addr", imem_addr, 32'h200);

    // mid-cycle async reset with entries queued
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] rp;
      rp = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16))
                               : $urandom;
      step(($urandom % 8) == 0, rp, ($urandom % 3) != 0,
           ($urandom % 60) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
